// File: rtl/mtr_pwm_decode.sv
// rtl/mtr_pwm_decode.sv - rebuilds signed duty from a PWM/DIR pair, flags stuck or mistimed PWM
// Optional period compare enabled by defining MTR_PWM_PERIOD_CHK_EN.
module mtr_pwm_decode #(
    parameter int PERIOD  = 2048,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PWM,
    input  logic        DIR,
    output logic [11:0] duty,
    output logic        duty_vld,
    output logic        stuck,
    output logic        period_err
);

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_MEAS  = 2'd1;
    localparam logic [1:0] ST_STUCK = 2'd2;

    localparam logic [12:0] TIMEOUT_C = 13'(TIMEOUT);

    generate
        if (TIMEOUT <= PERIOD) begin : g_bad_cfg
            $error("mtr_pwm_decode: TIMEOUT must exceed PERIOD");
        end
    endgenerate

    logic        pwm_s1, pwm_s, pwm_prev;
    logic        dir_s1, dir_s;
    logic        dir_cap;
    logic [12:0] per_cnt;
    logic [11:0] hi_cnt;
    logic [1:0]  state;

    logic        rise;
    logic        timeout_hit;
    logic        meas_done;
    logic        enter_stuck;
    logic [11:0] level_duty;
    logic [11:0] meas_duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_s1   <= 1'b0;
            pwm_s    <= 1'b0;
            pwm_prev <= 1'b0;
            dir_s1   <= 1'b0;
            dir_s    <= 1'b0;
        end else begin
            pwm_s1   <= PWM;
            pwm_s    <= pwm_s1;
            pwm_prev <= pwm_s;
            dir_s1   <= DIR;
            dir_s    <= dir_s1;
        end
    end

    assign rise        = pwm_s & ~pwm_prev;
    assign timeout_hit = (per_cnt == TIMEOUT_C);
    assign meas_done   = (state == ST_MEAS) && rise;
    assign enter_stuck = ((state == ST_WAIT) || (state == ST_MEAS)) && !rise && timeout_hit;

    // A held-high output reports full-scale duty in the held direction.
    assign level_duty = pwm_s ? (dir_s ? 12'h801 : 12'h7FF) : 12'h000;
    assign meas_duty  = dir_cap ? (12'h000 - hi_cnt) : hi_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= 13'd0;
            hi_cnt  <= 12'd0;
            dir_cap <= 1'b0;
        end else if (rise) begin
            per_cnt <= 13'd1;
            hi_cnt  <= 12'd1;
            dir_cap <= dir_s;
        end else begin
            if (per_cnt != 13'h1FFF) begin
                per_cnt <= per_cnt + 13'd1;
            end
            if (pwm_s && (hi_cnt != 12'h7FF)) begin
                hi_cnt <= hi_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT;
            duty     <= 12'h000;
            duty_vld <= 1'b0;
            stuck    <= 1'b0;
        end else begin
            duty_vld <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (rise) begin
                        state <= ST_MEAS;
                    end else if (timeout_hit) begin
                        state    <= ST_STUCK;
                        stuck    <= 1'b1;
                        duty     <= level_duty;
                        duty_vld <= 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        duty     <= meas_duty;
                        duty_vld <= 1'b1;
                    end else if (timeout_hit) begin
                        state    <= ST_STUCK;
                        stuck    <= 1'b1;
                        duty     <= level_duty;
                        duty_vld <= 1'b1;
                    end
                end
                ST_STUCK: begin
                    // A rise restarts measurement; the period it opens is partial.
                    if (rise) begin
                        state <= ST_WAIT;
                        stuck <= 1'b0;
                    end else if (pwm_s != pwm_prev) begin
                        duty     <= level_duty;
                        duty_vld <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_WAIT;
                    stuck <= 1'b0;
                end
            endcase
        end
    end

`ifdef MTR_PWM_PERIOD_CHK_EN
    localparam logic [12:0] PERIOD_C = 13'(PERIOD);

    logic period_err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_err_r <= 1'b0;
        end else if (enter_stuck) begin
            period_err_r <= 1'b1;
        end else if (meas_done) begin
            period_err_r <= (per_cnt != PERIOD_C);
        end
    end

    assign period_err = period_err_r;
`else
    logic unused_chk;
    assign unused_chk = meas_done ^ enter_stuck;
    assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_mtr_pwm_decode.sv
// tb/tb_mtr_pwm_decode.sv - scoreboard bench for mtr_pwm_decode with a period-level reference model
module tb_mtr_pwm_decode;

`ifdef MTR_PWM_PERIOD_CHK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct {
        logic [11:0] duty;
        logic        stk;
        logic        perr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_i = 1'b0;
    logic        dir_i = 1'b0;
    logic [11:0] duty;
    logic        duty_vld;
    logic        stuck;
    logic        period_err;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   discard = 1;
    int   cur_high = 0;
    int   cur_len = 0;
    bit   cur_dir = 1'b0;

    mtr_pwm_decode #(.PERIOD(2048), .TIMEOUT(4096)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PWM        (pwm_i),
        .DIR        (dir_i),
        .duty       (duty),
        .duty_vld   (duty_vld),
        .stuck      (stuck),
        .period_err (period_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] mk_duty(input int high, input bit dir);
        int v;
        v = dir ? -high : high;
        return v[11:0];
    endfunction

    // A rise closes the running period; the first rise(s) after reset or stuck are partial.
    task automatic model_rise();
        exp_t e;
        if (discard > 0) begin
            discard--;
        end else begin
            e.duty = mk_duty(cur_high, cur_dir);
            e.stk  = 1'b0;
            e.perr = PCHK && (cur_len != 2048);
            q.push_back(e);
        end
    endtask

    task automatic push_stuck(input logic [11:0] d);
        exp_t e;
        e.duty = d;
        e.stk  = 1'b1;
        e.perr = PCHK;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int len, input int high, input bit dir,
                          input bit toggle, input int abort_at);
        for (int c = 0; c < len; c++) begin
            pwm_i = (c < high);
            if (c == 0) begin
                dir_i = dir;
                model_rise();
                cur_high = high;
                cur_len  = len;
                cur_dir  = dir;
            end else if (toggle && c == len / 2) begin
                dir_i = ~dir_i;
            end
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_duty", 32'(duty), 32'h0);
                chk("rst_mid_vld", 32'(duty_vld), 32'h0);
                chk("rst_mid_stuck", 32'(stuck), 32'h0);
                chk("rst_mid_perr", 32'(period_err), 32'h0);
                q.delete();
                discard = 1;
            end
            if (abort_at >= 0 && c == abort_at + 3) rst_n = 1'b1;
            step();
        end
    endtask

    task automatic hold(input bit level, input bit dir, input int n);
        if (level && !pwm_i) model_rise();
        pwm_i = level;
        dir_i = dir;
        push_stuck(level ? (dir ? 12'h801 : 12'h7FF) : 12'h000);
        discard = 2;
        repeat (n) step();
        if (level) begin
            pwm_i = 1'b0;
            push_stuck(12'h000);
            repeat (10) step();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && duty_vld) begin
            if (q.size() == 0) begin
                chk("unexpected_vld", 32'(duty), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("duty", 32'(duty), 32'(e.duty));
                chk("stuck_at_vld", 32'(stuck), 32'(e.stk));
                chk("period_err", 32'(period_err), 32'(e.perr));
            end
        end
    end

    initial begin
        int len;
        int high;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty", 32'(duty), 32'h0);
        chk("rst_vld", 32'(duty_vld), 32'h0);
        chk("rst_stuck", 32'(stuck), 32'h0);
        chk("rst_perr", 32'(period_err), 32'h0);
        rst_n = 1'b1;

        hold(1'b0, 1'b0, 4300);
        chk("stuck_held", 32'(stuck), 32'h1);

        repeat (3) period(2048, 128, 1'b0, 1'b0, -1);
        repeat (3) period(2048, 205, 1'b1, 1'b1, -1);
        repeat (3) period(2048, 2047, 1'b0, 1'b0, -1);
        hold(1'b1, 1'b1, 4300);
        repeat (3) period(2048, 256, 1'b0, 1'b0, -1);
        chk("stuck_released", 32'(stuck), 32'h0);

        period(2048, 512, 1'b0, 1'b0, 1000);
        repeat (3) period(2048, 512, 1'b0, 1'b0, -1);

        repeat (3) period(1500, 300, 1'b0, 1'b0, -1);
        repeat (3) period(2048, 300, 1'b1, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            len  = $urandom_range(2600, 1024);
            high = $urandom_range(len - 1, 1);
            if (high > 2047) high = 2047;
            period(len, high, 1'($urandom), 1'($urandom), -1);
        end
        period(2048, 64, 1'b0, 1'b0, -1);
        repeat (10) step();
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mtr_pwm_decode.md
Name: mtr_pwm_decode

Overview:
- Reads back one motor channel's PWM/DIR pair, as produced by mtr_drv, and reconstructs the signed 12-bit duty that generated it.
- One instance per side, on PWML/DIRL and PWMR/DIRR, for closed-loop self-check and on-chip monitoring of the motor driver.
- Measures high time per PWM period, applies DIR as sign, and flags stuck or mistimed outputs.

Parameters:
- PERIOD, 2048, expected PWM period in clk cycles (11-bit PWM).
- TIMEOUT, 4096, clk cycles without a PWM rising edge before declaring the output stuck; must be > PERIOD.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- PWM  input  1  PWM from the motor driver; may be asynchronous.
- DIR  input  1  direction from the motor driver; 1 = negative duty.
- duty  output  12  reconstructed signed duty, two's complement.
- duty_vld  output  1  one-clk strobe when duty is updated.
- stuck  output  1  high while PWM has no rising edge within TIMEOUT.
- period_err  output  1  last measured period != PERIOD (see Optional Feature).

Behaviour:
- Reset: duty=0, duty_vld=0, stuck=0, period_err=0, state=WAIT, all counters 0. Reset is asynchronous.
- Synchronisation: PWM and DIR each pass through a 2-flop synchronizer.
- Edge detect: a third flop on PWM_s gives pwm_prev; rise = PWM_s & ~pwm_prev.
- Latency: duty_vld is high in the cycle after the 3rd clk edge that samples PWM high at the pin.
- per_cnt: 13-bit, counts clk cycles since the last rise.
  - Loads 1 on rise.
  - Otherwise increments, saturating at 13'h1FFF.
- hi_cnt: 12-bit, counts cycles with PWM_s=1 since the last rise.
  - Loads 1 on rise.
  - Otherwise increments when PWM_s=1, saturating at 12'h7FF.
- dir_cap: DIR_s captured on each rise. It applies to the period that starts at that rise.
- States:
  - WAIT: after reset or leaving STUCK. The first period is partial and discarded.
    - On rise: go to MEAS, no duty_vld.
    - If per_cnt==TIMEOUT: go to STUCK.
  - MEAS, on rise: a full period completes.
    - mag = hi_cnt (11 bits, max 0x7FF).
    - duty = dir_cap ? -mag : mag (12-bit). mag=0 gives 0 regardless of dir_cap.
    - Pulse duty_vld; stay in MEAS.
  - MEAS, if per_cnt==TIMEOUT: go to STUCK and pulse duty_vld once.
    - PWM_s=0: duty=0.
    - PWM_s=1: duty = DIR_s ? 12'h801 : 12'h7FF.
  - STUCK: stuck=1.
    - While in STUCK, if PWM_s changes level, re-evaluate duty as above and pulse duty_vld.
    - On rise: go to WAIT, stuck=0 in the same cycle.
- Entry into STUCK from WAIT (e.g. duty 0 from reset) behaves the same as from MEAS: one duty_vld with the level-based duty.
- Simultaneous rise and per_cnt==TIMEOUT: rise wins.
- DIR changing mid-period does not affect the current period's result. It takes effect at the next rise.
- duty holds its value between strobes.
- Reset mid-period discards all partial counts.

Optional Feature:
- Macro: MTR_PWM_PERIOD_CHK_EN.
- Defined:
  - On each MEAS rise, period_err is registered as (per_cnt != PERIOD), concurrent with duty_vld.
  - On entry to STUCK, period_err = 1.
  - On return to MEAS with a correct period, period_err clears.
- Undefined: period_err is tied 0 and the compare logic is absent. All other behaviour is unchanged.

Test Plan:
- Drive mtr_drv with lft_duty=12'h080, period 2048 -> after the first discarded period, duty_vld every 2048 clks, duty=12'h080, stuck=0, period_err=0.
- lft_duty=12'hF33 (DIR=1, 205 high cycles) -> duty=12'hF33 each period.
- lft_duty=12'h000 from reset -> no rise; TIMEOUT clks after reset, stuck=1, one duty_vld, duty=0.
- lft_duty=12'h7FF (2047 high/2048) -> duty=12'h7FF. Then force PWM high constantly with DIR=1 -> after TIMEOUT, stuck=1, duty=12'h801. Release to normal PWM -> stuck=0, first period discarded, then correct duty.
- Assert rst_n=0 at 1000 clks into a period of duty 12'h200 -> all outputs 0 immediately. After release, the first partial period produces no duty_vld, and the next full period gives duty=12'h200.
- With MTR_PWM_PERIOD_CHK_EN: drive a 1500-clk period, 300 high -> duty=12'h12C, period_err=1. Return to 2048 period -> period_err=0. Without the macro -> period_err stays 0.
